mic_pdm_packer: RTL

Capture front end for the microphone record path. It divides `clk` to generate the microphone serial clock and samples the 1-bit `sdata` stream once per serial-clock period. It packs the samples into `WORD_W`-bit words, buffers them in a small FIFO, and presents them on a valid/ready interface to the PSRAM write sequencer downstream. This decouples mic sampling from AXI write latency, so a slow write response no longer stalls or corrupts capture.

---
 rtl/mic_pdm_packer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/mic_pdm_packer.sv
// Microphone capture front end: divides clk into sclk, packs 1-bit samples into words, queues them in a FIFO.
// Optional macro MIC_PACKER_MSB_FIRST_EN: first sample of a word lands in the MSB instead of bit 0.
module mic_pdm_packer #(
   parameter int CLK_DIV    = 32,
   parameter int WORD_W     = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        S_AXI_ARESETN,
   input  logic                        en,
   input  logic                        sdata,
   output logic                        sclk,
   output logic                        ncs,
   output logic [WORD_W-1:0]           word_data,
   output logic                        word_valid,
   input  logic                        word_ready,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic                        overflow
);
   localparam int DIV_W  = $clog2(CLK_DIV);
   localparam int IDX_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam int ADDR_W = $clog2(FIFO_DEPTH);
   localparam int PTR_W  = ADDR_W + 1;

   typedef enum logic {ST_IDLE = 1'b0, ST_CAPTURE = 1'b1} state_t;

   logic [DIV_W-1:0]  r_div_cnt;
   logic [DIV_W-1:0]  w_div_next;
   logic              r_sclk;
   logic              r_ncs;
   logic              r_en_d;
   logic              w_strobe;
   logic              w_en_rise;
   state_t            r_state;
   state_t            w_state_next;
   logic              w_start;
   logic              w_sample;
   logic              w_clear_idx;
   logic [IDX_W-1:0]  r_bit_idx;
   logic [IDX_W-1:0]  w_pos;
   logic [WORD_W-1:0] r_shift;
   logic [WORD_W-1:0] w_shift_next;
   logic              w_push;
   logic [WORD_W-1:0] r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [PTR_W-1:0]  w_level;
   logic              w_full;
   logic              w_empty;
   logic              w_pop;
   logic              w_wr_en;
   logic              r_overflow;

   assign w_div_next = (r_div_cnt == DIV_W'(CLK_DIV - 1)) ? '0 : r_div_cnt + DIV_W'(1);
   assign w_strobe   = (r_div_cnt == DIV_W'(CLK_DIV - 1));
   assign w_en_rise  = en & ~r_en_d;

   // sclk is registered from the next count so it is high exactly while div_cnt is in the upper half
   always_ff @(posedge clk or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         r_div_cnt <= '0;
         r_sclk    <= 1'b0;
         r_ncs     <= 1'b1;
         r_en_d    <= 1'b0;
      end else begin
         r_div_cnt <= w_div_next;
         r_sclk    <= (w_div_next >= DIV_W'(CLK_DIV / 2));
         r_ncs     <= ~en;
         r_en_d    <= en;
      end
   end

   always_ff @(posedge clk or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_start      = 1'b0;
      w_sample     = 1'b0;
      w_clear_idx  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_en_rise) begin
               w_state_next = ST_CAPTURE;
               w_start      = 1'b1;
            end
         end
         ST_CAPTURE: begin
            if (!en) begin
               w_state_next = ST_IDLE;
               w_clear_idx  = 1'b1;
            end else if (w_strobe) begin
               w_sample = 1'b1;
            end
         end
      endcase
   end

`ifdef MIC_PACKER_MSB_FIRST_EN
   assign w_pos = IDX_W'(WORD_W - 1) - r_bit_idx;
`else
   assign w_pos = r_bit_idx;
`endif

   always_comb begin
      w_shift_next        = r_shift;
      w_shift_next[w_pos] = sdata;
   end

   assign w_push = w_sample && (r_bit_idx == IDX_W'(WORD_W - 1));

   always_ff @(posedge clk or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         r_bit_idx <= '0;
         r_shift   <= '0;
      end else if (w_start) begin
         r_bit_idx <= '0;
         r_shift   <= '0;
      end else if (w_clear_idx) begin
         r_bit_idx <= '0;
      end else if (w_sample) begin
         r_shift   <= w_shift_next;
         r_bit_idx <= w_push ? '0 : r_bit_idx + IDX_W'(1);
      end
   end

   // Pointers carry one extra bit so full and empty are distinguishable
   assign w_level = r_wr_ptr - r_rd_ptr;
   assign w_empty = (w_level == '0);
   assign w_full  = (w_level == PTR_W'(FIFO_DEPTH));
   assign w_pop   = !w_empty && word_ready;
   assign w_wr_en = w_push && (!w_full || w_pop);

   always_ff @(posedge clk or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_wr_en) begin
         r_mem[r_wr_ptr[ADDR_W-1:0]] <= w_shift_next;
      end
   end

   always_ff @(posedge clk or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         if (w_start) begin
            r_overflow <= 1'b0;
         end else if (w_push && w_full && !w_pop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   assign sclk       = r_sclk;
   assign ncs        = r_ncs;
   assign word_data  = r_mem[r_rd_ptr[ADDR_W-1:0]];
   assign word_valid = !w_empty;
   assign fifo_level = w_level;
   assign overflow   = r_overflow;

endmodule
